// File: rtl/piso_shift_reg_pkg.sv
// piso_shift_reg_pkg: shared state encoding and clog2 helper for the serial data-storage blocks
// Contents:
//   state_e - IDLE (no word held) / SHIFT (word being emitted)
//   clog2   - minimum bit count able to hold values 0..n-1, never less than 1
package piso_shift_reg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: loadable down-counter with decrement enable and zero flag
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset, clears the count
//   load_i     - load load_val_i (wins over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one; saturates at zero
//   zero_o     - count is zero
module piso_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        zero_o = (cnt_q == '0);
        cnt_d  = load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shift register with valid/ready on both sides
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   load_valid - upstream offers load_data
//   load_ready - a word can be accepted this cycle (combinational from ser_ready)
//   load_data  - parallel word, captured on the load handshake
//   ser_out    - current serial bit
//   ser_valid  - ser_out holds a valid bit
//   ser_last   - ser_out is the final bit of the word
//   ser_ready  - downstream accepts the current bit
module piso_shift_reg
    import piso_shift_reg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready
);

    localparam int            CW   = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             cnt_zero, bit_hs, load_hs;

    always_comb begin
        ser_valid  = (state_q == ST_SHIFT);
        ser_last   = ser_valid && cnt_zero;
        ser_out    = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        bit_hs     = ser_valid && ser_ready;
        // Accepting on the last-bit beat lets back-to-back words stream without a bubble.
        load_ready = !ser_valid || (bit_hs && ser_last);
        load_hs    = load_valid && load_ready;
        shift_d    = load_hs ? load_data
                   : bit_hs  ? (MSB_FIRST ? shift_q << 1 : shift_q >> 1)
                   : shift_q;
        state_d    = load_hs ? ST_SHIFT : (bit_hs && ser_last) ? ST_IDLE : state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    piso_bit_counter #(.CW(CW)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_hs),
        .load_val_i (LAST),
        .dec_i      (bit_hs),
        .zero_o     (cnt_zero)
    );

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed and random checks of both bit orders against a word/index model
module tb_piso_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         ser_ready = 1'b0;
    logic         dm_lr, dm_out, dm_valid, dm_last;
    logic         dl_lr, dl_out, dl_valid, dl_last;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_loads = 0;
    bit started = 1'b0;

    bit           mb = 1'b0;
    int           mk = 0;
    logic [W-1:0] mword = '0;

    bit cap_m[$];
    bit cap_l[$];

    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(dm_lr),
        .load_data(load_data), .ser_out(dm_out), .ser_valid(dm_valid),
        .ser_last(dm_last), .ser_ready(ser_ready)
    );

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(dl_lr),
        .load_data(load_data), .ser_out(dl_out), .ser_valid(dl_valid),
        .ser_last(dl_last), .ser_ready(ser_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // Model: a held word plus the index of the bit currently presented.
    always @(posedge clk) begin
        bit hs, lr;
        cyc++;
        if (!rst_n) begin
            started = 1'b1;
            mb = 1'b0;
            mk = 0;
        end else begin
            hs = mb && ser_ready;
            lr = !mb || (hs && mk == W - 1);
            if (hs) begin
                if (mk == W - 1) mb = 1'b0;
                else mk++;
            end
            if (load_valid && lr) begin
                mb = 1'b1;
                mk = 0;
                mword = load_data;
                n_loads++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit lr;
            lr = !mb || (ser_ready && mk == W - 1);
            chk("valid_m", dm_valid, mb);
            chk("valid_l", dl_valid, mb);
            chk("last_m", dm_last, mb && mk == W - 1);
            chk("last_l", dl_last, mb && mk == W - 1);
            chk("lready_m", dm_lr, lr);
            chk("lready_l", dl_lr, lr);
            if (mb) begin
                chk("out_m", dm_out, mword[W-1-mk]);
                chk("out_l", dl_out, mword[mk]);
            end
            if (rst_n && dm_valid && ser_ready) cap_m.push_back(dm_out);
            if (rst_n && dl_valid && ser_ready) cap_l.push_back(dl_out);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_m.delete();
        cap_l.delete();
    endtask

    task automatic load(input logic [W-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        step(1);
        load_valid = 1'b0;
        load_data  = W'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!dm_valid && !dl_valid) return;
            step(1);
        end
        chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int t0;
        step(3);
        chk("rst_valid", {dm_valid, dl_valid}, 0);
        chk("rst_last", {dm_last, dl_last}, 0);
        chk("rst_out", {dm_out, dl_out}, 0);
        chk("rst_lready", {dm_lr, dl_lr}, 2'b11);
        rst_n = 1'b1;
        step(1);

        clear_cap();
        ser_ready = 1'b1;
        load(8'hA5);
        wait_idle();
        chk("a5_count", cap_m.size(), 8);
        chk("a5_msb", pack(cap_m), 32'hA5);
        chk("a5_lsb", pack(cap_l), 32'hA5);

        clear_cap();
        load(8'h81);
        for (int i = 0; i < 60 && dm_valid; i++) begin
            ser_ready = (i % 4 == 0) || (i % 4 == 3);
            step(1);
        end
        ser_ready = 1'b1;
        wait_idle();
        chk("bp_count", cap_l.size(), 8);
        chk("bp_lsb", pack(cap_l), 32'h81);
        chk("bp_msb", pack(cap_m), 32'h81);

        clear_cap();
        n_loads = 0;
        load_valid = 1'b1;
        load_data  = 8'hF0;
        step(1);
        t0 = cyc;
        load_data = 8'h0F;
        for (int i = 0; i < 40 && n_loads < 2; i++) step(1);
        load_valid = 1'b0;
        wait_idle();
        chk("b2b_span", cyc - t0, 16);
        chk("b2b_msb", pack(cap_m), 32'hF00F);
        chk("b2b_lsb", pack(cap_l), 32'h0FF0);

        clear_cap();
        load(8'hC3);
        step(3);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        #1;
        chk("busy_lready", {dm_lr, dl_lr}, 0);
        step(1);
        load_valid = 1'b0;
        wait_idle();
        chk("busy_msb", pack(cap_m), 32'hC3);
        chk("busy_lsb", pack(cap_l), 32'hC3);

        load(8'h5A);
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("midrst_valid", {dm_valid, dl_valid}, 0);
        rst_n = 1'b1;
        clear_cap();
        load(8'h3C);
        wait_idle();
        chk("midrst_count", cap_m.size(), 8);
        chk("midrst_msb", pack(cap_m), 32'h3C);
        chk("midrst_lsb", pack(cap_l), 32'h3C);

        for (int i = 0; i < 600; i++) begin
            rst_n      = ($urandom_range(0, 60) != 0);
            load_valid = 1'($urandom);
            load_data  = W'($urandom);
            ser_ready  = ($urandom_range(0, 3) != 0);
            step(1);
        end
        rst_n = 1'b1;
        load_valid = 1'b0;
        ser_ready = 1'b1;
        step(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in, serial-out shift register with valid/ready handshakes on both sides. It accepts a WIDTH-bit word from an upstream storage element and emits it one bit per accepted beat, flagging the final bit. It is the read-out end for the team's serial-in, parallel-out capture registers and sits between a register/DFF bank and a serial link or serial consumer.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 emits bit WIDTH-1 first; 0 emits bit 0 first.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
- load_valid  input  1  upstream offers load_data.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word, sampled only on load handshake.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_last  output  1  ser_out is the final bit of the word.
- ser_ready  input  1  downstream accepts the current bit.

## Operation
- States: IDLE (no word held) and SHIFT (word being emitted).
- Load handshake: load_valid && load_ready at a rising edge.
- Bit handshake: ser_valid && ser_ready at a rising edge.
- load_ready = (state == IDLE) || (ser_valid && ser_ready && ser_last). This is combinational and includes a path from ser_ready to load_ready, which is intended.
- IDLE + load handshake → SHIFT:
  - Capture load_data into the shift register.
  - Set bit counter = WIDTH-1.
- SHIFT + bit handshake with counter > 0:
  - Shift by one position toward the output end: left if MSB_FIRST, right otherwise. Shift in 0.
  - Decrement the counter.
- SHIFT + bit handshake with counter == 0, i.e. the last bit:
  - With a simultaneous load handshake: capture the new word, reload the counter to WIDTH-1, stay in SHIFT. No bubble.
  - Otherwise: go to IDLE.
- SHIFT without a bit handshake: hold everything. ser_out, ser_valid and ser_last stay stable while ser_ready=0.
- ser_out = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0].
- ser_valid = (state == SHIFT).
- ser_last = (state == SHIFT) && (counter == 0).
- Counter width is clog2(WIDTH). It never wraps below 0; counter == 0 is the exit condition.
- load_valid in SHIFT, other than on the last-bit beat, is ignored because load_ready=0. The upstream must hold its data.
- load_data is ignored when there is no load handshake.

## Timing
- Reset, when rst_n=0 at an edge, takes effect at that edge regardless of state, including mid-word. The partial word is discarded.
- Values after reset: state=IDLE, shift_reg=0, counter=0. Outputs: ser_valid=0, ser_last=0, ser_out=0, load_ready=1.
- While rst_n=0, load handshakes are not honored. The registers keep loading reset values.
- Latency: a load handshake at edge N gives ser_valid=1 with the first bit after edge N.
- With ser_ready held at 1, bit k (k = 0..WIDTH-1) is presented in cycle N+1+k. ser_last is high in cycle N+WIDTH.
- Throughput: with back-to-back loads and ser_ready=1, there is one bit per cycle with no idle cycle between words.
- From a load in IDLE to the next possible load handshake: WIDTH cycles minimum.

## Structure
- State encoding constants (ST_IDLE=1'b0, ST_SHIFT=1'b1) live in the shared data-storage package/include.
- The clog2 helper also lives there, shared with the SIPO capture block.
- Natural sub-module: piso_bit_counter. It is a down-counter with load, decrement enable, and a zero flag, and is reused by the SIPO side.
- Shift register, FSM and handshake logic stay in piso_shift_reg.

## Test plan
- Reset/defaults:
  - Stimulus: hold rst_n=0 for 3 edges, then release.
  - Required: ser_valid=0, ser_last=0, ser_out=0, load_ready=1.
- MSB-first word:
  - Stimulus: WIDTH=8, MSB_FIRST=1, load 8'hA5, ser_ready=1.
  - Required: ser_out sequence 1,0,1,0,0,1,0,1 on consecutive cycles; ser_last only on the 8th bit; then IDLE.
- LSB-first with backpressure:
  - Stimulus: MSB_FIRST=0, load 8'h81, ser_ready toggled 1,0,0,1,… .
  - Required: sequence 1,0,0,0,0,0,0,1; outputs stable across ser_ready=0 cycles; exactly 8 handshakes.
- Back-to-back words:
  - Stimulus: load 8'hF0, then offer 8'h0F with load_valid held.
  - Required: load_ready=1 only on the last-bit beat; 16 consecutive valid bits 1111000000001111; no gap.
- Load ignored while busy:
  - Stimulus: during SHIFT (bit 3 of 8'hC3), pulse load_valid with 8'hFF.
  - Required: load_ready=0; the emitted word is still 8'hC3.
- Reset mid-word:
  - Stimulus: assert rst_n=0 at bit 4 of 8'h5A, then release and load 8'h3C.
  - Required: ser_valid drops after the reset edge; the next output is a clean 00111100 with ser_last on the 8th bit.
